prefetch_rd_arbiter: RTL and testbench
======================================

# prefetch_rd_arbiter

Shares the single DRAM read-address/read-data channel pair between the demand path (reads forwarded from the accelerator side) and the prefetch engine. It picks one AR request per slot with demand priority, plus a programmable anti-starvation guarantee for prefetches. It registers the winning request toward DRAM and records the source of every issued burst in an in-order tag FIFO. R beats are then steered back to the requester that owns the oldest outstanding burst. The block sits between `prefetcherTop` and the `axi_ram`/DDR slave.

## Interface
- ADDR_BITS, 16: address width
- BURST_LEN_WIDTH, 8: AR len width
- TID_WIDTH, 8: transaction ID width
- DATA_WIDTH, 8: R data width
- LOG_OUTSTANDING, 3: log2 of the maximum number of outstanding bursts (tag FIFO depth)
- STARVE_WIDTH, 6: width of the starvation limit and counter

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  grant enable; 0 blocks new grants, drain continues
- crs_starve_limit  in  STARVE_WIDTH  consecutive prefetch losses before a forced prefetch grant; 0 = strict demand priority
- d_ar_valid/d_ar_ready  in/out  1  demand AR handshake
- d_ar_addr, d_ar_len, d_ar_id  in  ADDR_BITS/BURST_LEN_WIDTH/TID_WIDTH  demand AR payload
- p_ar_valid/p_ar_ready  in/out  1  prefetch AR handshake
- p_ar_addr, p_ar_len, p_ar_id  in  as above  prefetch AR payload
- m_ar_valid/m_ar_ready  out/in  1  DRAM AR handshake
- m_ar_addr, m_ar_len, m_ar_id  out  as above  registered winner payload
- m_r_valid/m_r_ready  in/out  1  DRAM R handshake
- m_r_last, m_r_data, m_r_id  in  1/DATA_WIDTH/TID_WIDTH  DRAM R payload
- d_r_valid/d_r_ready  out/in  1  demand R handshake; d_r_last/d_r_data/d_r_id mirror m_r_*
- p_r_valid/p_r_ready  out/in  1  prefetch R handshake; p_r_last/p_r_data/p_r_id mirror m_r_*
- outstanding  out  LOG_OUTSTANDING+1  bursts granted but not yet fully returned
- starve_cnt  out  STARVE_WIDTH  current starvation counter

## Operation
- AR output register (holds one slot): free when m_ar_valid=0 or m_ar_ready=1.
- A grant is possible when all three hold: the slot is free, en=1, and outstanding < 2^LOG_OUTSTANDING.
- Winner selection:
  - Only one requester valid: that one wins.
  - Both valid: prefetch wins if crs_starve_limit≠0 and starve_cnt ≥ crs_starve_limit; otherwise demand wins.
- d_ar_ready / p_ar_ready are combinational: high only for the winner in a grant-possible cycle.
- On grant:
  - Payload is loaded into m_ar_*; m_ar_valid=1.
  - Source bit is pushed into the tag FIFO (0=demand, 1=prefetch); outstanding increments.
- Starvation counter:
  - Increments (saturating) on each cycle where the prefetch requester is valid and demand is granted.
  - Clears when the prefetch requester is granted.
  - Holds otherwise.
- R steering (combinational): when the FIFO is non-empty, the head tag selects the destination.
  - Selected side: r_valid = m_r_valid.
  - m_r_ready = selected side's r_ready.
  - Other side: valid = 0.
  - FIFO empty: m_r_ready=0 and both r_valid=0.
- A beat with m_r_valid & m_r_ready & m_r_last pops the FIFO; outstanding decrements.
- m_r_id is not used for routing; DRAM returns bursts in order.

## Timing
- Reset (async, immediate): m_ar_valid=0, m_ar_addr/len/id=0, d/p_ar_ready=0, d/p_r_valid=0, m_r_ready=0, outstanding=0, starve_cnt=0, FIFO empty. Reset mid-burst discards all tags and any pending AR.
- AR latency: request accepted in cycle N → m_ar_valid in cycle N+1. Back-to-back grants are possible every cycle while m_ar_ready=1.
- m_ar_* stay stable while m_ar_valid=1 and m_ar_ready=0.
- R path has zero latency, pass-through.
- Grant and last-beat pop in the same cycle: FIFO push and pop both occur; outstanding is unchanged.
- FIFO full: no grant, even if a pop happens that cycle. The full check uses the registered count.
- FIFO pointers wrap modulo 2^LOG_OUTSTANDING. The count is LOG_OUTSTANDING+1 bits, so full and empty are distinguishable.
- en deasserted: the pending m_ar beat still completes, R drain continues, and starve_cnt holds.

## Test plan
- Single demand read: addr=0x0EEF, len=0, id=5 → m_ar_valid the next cycle with the same payload; one R beat appears on d_r_* with d_r_last=1; outstanding goes 0→1→0.
- Starvation: crs_starve_limit=3, demand and prefetch held valid continuously, m_ar_ready=1 → grant order D,D,D,P,D,D,D,P; starve_cnt goes 1,2,3,0.
- Strict priority: crs_starve_limit=0, both held valid for 10 cycles → every grant goes to demand; starve_cnt saturates at its maximum.
- Outstanding full: LOG_OUTSTANDING=3, m_r_valid=0, 9 demand requests → 8 grants, then d_ar_ready=0. One R last beat frees a slot; the 9th is granted the cycle after.
- Ordering: demand len=3, then prefetch len=1, then demand len=0 → beats 4/2/1 routed to d/p/d respectively. Holding p_r_ready low stalls m_r_ready and does not leak beats to the demand side.
- Reset mid-operation: assert rst with 2 bursts outstanding and m_ar_valid=1 → all outputs at their reset values within the same cycle; after release, a new demand read is issued and returned normally.

Source files
------------

// File: rtl/prefetch_rd_arbiter.sv
// rtl/prefetch_rd_arbiter.sv - demand/prefetch AR arbiter with in-order R steering
// Demand has priority; a programmable starvation limit forces an occasional prefetch grant.
module prefetch_rd_arbiter #(
  parameter int ADDR_BITS       = 16,
  parameter int BURST_LEN_WIDTH = 8,
  parameter int TID_WIDTH       = 8,
  parameter int DATA_WIDTH      = 8,
  parameter int LOG_OUTSTANDING = 3,
  parameter int STARVE_WIDTH    = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [STARVE_WIDTH-1:0]    crs_starve_limit,
  input  logic                       d_ar_valid,
  output logic                       d_ar_ready,
  input  logic [ADDR_BITS-1:0]       d_ar_addr,
  input  logic [BURST_LEN_WIDTH-1:0] d_ar_len,
  input  logic [TID_WIDTH-1:0]       d_ar_id,
  input  logic                       p_ar_valid,
  output logic                       p_ar_ready,
  input  logic [ADDR_BITS-1:0]       p_ar_addr,
  input  logic [BURST_LEN_WIDTH-1:0] p_ar_len,
  input  logic [TID_WIDTH-1:0]       p_ar_id,
  output logic                       m_ar_valid,
  input  logic                       m_ar_ready,
  output logic [ADDR_BITS-1:0]       m_ar_addr,
  output logic [BURST_LEN_WIDTH-1:0] m_ar_len,
  output logic [TID_WIDTH-1:0]       m_ar_id,
  input  logic                       m_r_valid,
  output logic                       m_r_ready,
  input  logic                       m_r_last,
  input  logic [DATA_WIDTH-1:0]      m_r_data,
  input  logic [TID_WIDTH-1:0]       m_r_id,
  output logic                       d_r_valid,
  input  logic                       d_r_ready,
  output logic                       d_r_last,
  output logic [DATA_WIDTH-1:0]      d_r_data,
  output logic [TID_WIDTH-1:0]       d_r_id,
  output logic                       p_r_valid,
  input  logic                       p_r_ready,
  output logic                       p_r_last,
  output logic [DATA_WIDTH-1:0]      p_r_data,
  output logic [TID_WIDTH-1:0]       p_r_id,
  output logic [LOG_OUTSTANDING:0]   outstanding,
  output logic [STARVE_WIDTH-1:0]    starve_cnt
);

  localparam int DEPTH = 1 << LOG_OUTSTANDING;
  localparam logic [LOG_OUTSTANDING:0]   CNT_ONE    = 1;
  localparam logic [LOG_OUTSTANDING-1:0] PTR_ONE    = 1;
  localparam logic [STARVE_WIDTH-1:0]    STARVE_ONE = 1;
  localparam logic [STARVE_WIDTH-1:0]    STARVE_MAX = '1;

  logic [DEPTH-1:0]           tags;
  logic [LOG_OUTSTANDING-1:0] wr_ptr;
  logic [LOG_OUTSTANDING-1:0] rd_ptr;
  logic slot_free, fifo_full, fifo_empty, can_grant;
  logic force_p, pick_p, grant, pop, head_tag;

  // Count never exceeds DEPTH, so its top bit alone means full.
  assign fifo_full  = outstanding[LOG_OUTSTANDING];
  assign fifo_empty = (outstanding == '0);
  assign slot_free  = !m_ar_valid || m_ar_ready;
  assign can_grant  = !rst && slot_free && en && !fifo_full;

  assign force_p    = (crs_starve_limit != '0) && (starve_cnt >= crs_starve_limit);
  assign pick_p     = p_ar_valid && (!d_ar_valid || force_p);
  assign d_ar_ready = can_grant && d_ar_valid && !pick_p;
  assign p_ar_ready = can_grant && pick_p;
  assign grant      = d_ar_ready || p_ar_ready;

  // Head tag picks the R destination; bursts come back in issue order.
  assign head_tag  = tags[rd_ptr];
  assign d_r_valid = !fifo_empty && !head_tag && m_r_valid;
  assign p_r_valid = !fifo_empty && head_tag && m_r_valid;
  assign m_r_ready = !fifo_empty && (head_tag ? p_r_ready : d_r_ready);
  assign pop       = m_r_valid && m_r_ready && m_r_last;

  assign d_r_last = m_r_last;
  assign d_r_data = m_r_data;
  assign d_r_id   = m_r_id;
  assign p_r_last = m_r_last;
  assign p_r_data = m_r_data;
  assign p_r_id   = m_r_id;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ar_valid <= 1'b0;
      m_ar_addr  <= '0;
      m_ar_len   <= '0;
      m_ar_id    <= '0;
    end else if (grant) begin
      m_ar_valid <= 1'b1;
      m_ar_addr  <= p_ar_ready ? p_ar_addr : d_ar_addr;
      m_ar_len   <= p_ar_ready ? p_ar_len  : d_ar_len;
      m_ar_id    <= p_ar_ready ? p_ar_id   : d_ar_id;
    end else if (m_ar_ready) begin
      m_ar_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (p_ar_ready) begin
      starve_cnt <= '0;
    end else if (d_ar_ready && p_ar_valid && starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + STARVE_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
    end else begin
      if (grant) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
      if (grant && !pop)      outstanding <= outstanding + CNT_ONE;
      else if (!grant && pop) outstanding <= outstanding - CNT_ONE;
    end
  end

  // Tag storage needs no reset: entries are only read while the count says they are live.
  always_ff @(posedge clk) begin
    if (grant) tags[wr_ptr] <= p_ar_ready;
  end

endmodule

// File: tb/tb_prefetch_rd_arbiter.sv
// tb/tb_prefetch_rd_arbiter.sv - directed self-checking bench for prefetch_rd_arbiter
module tb_prefetch_rd_arbiter;
  logic clk = 1'b0;
  logic rst, en;
  logic [2:0]  crs_starve_limit;
  logic d_ar_valid, d_ar_ready, p_ar_valid, p_ar_ready;
  logic [15:0] d_ar_addr, p_ar_addr, m_ar_addr;
  logic [7:0]  d_ar_len, p_ar_len, m_ar_len, d_ar_id, p_ar_id, m_ar_id;
  logic m_ar_valid, m_ar_ready, m_r_valid, m_r_ready, m_r_last;
  logic [7:0]  m_r_data, m_r_id, d_r_data, d_r_id, p_r_data, p_r_id;
  logic d_r_valid, d_r_ready, d_r_last, p_r_valid, p_r_ready, p_r_last;
  logic [3:0]  outstanding;
  logic [2:0]  starve_cnt;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prefetch_rd_arbiter #(
    .ADDR_BITS(16), .BURST_LEN_WIDTH(8), .TID_WIDTH(8), .DATA_WIDTH(8),
    .LOG_OUTSTANDING(3), .STARVE_WIDTH(3)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .crs_starve_limit(crs_starve_limit),
    .d_ar_valid(d_ar_valid), .d_ar_ready(d_ar_ready), .d_ar_addr(d_ar_addr),
    .d_ar_len(d_ar_len), .d_ar_id(d_ar_id),
    .p_ar_valid(p_ar_valid), .p_ar_ready(p_ar_ready), .p_ar_addr(p_ar_addr),
    .p_ar_len(p_ar_len), .p_ar_id(p_ar_id),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr),
    .m_ar_len(m_ar_len), .m_ar_id(m_ar_id),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_last(m_r_last),
    .m_r_data(m_r_data), .m_r_id(m_r_id),
    .d_r_valid(d_r_valid), .d_r_ready(d_r_ready), .d_r_last(d_r_last),
    .d_r_data(d_r_data), .d_r_id(d_r_id),
    .p_r_valid(p_r_valid), .p_r_ready(p_r_ready), .p_r_last(p_r_last),
    .p_r_data(p_r_data), .p_r_id(p_r_id),
    .outstanding(outstanding), .starve_cnt(starve_cnt)
  );

  task automatic test_reset;
    #1;
    checks++; if (m_ar_valid !== 1'b0) begin errors++; $display("FAIL reset_m_ar_valid got %0b want 0", m_ar_valid); end
    checks++; if (m_ar_addr !== 16'h0) begin errors++; $display("FAIL reset_m_ar_addr got %h want 0", m_ar_addr); end
    checks++; if (outstanding !== 4'd0) begin errors++; $display("FAIL reset_outstanding got %0d want 0", outstanding); end
    checks++; if (starve_cnt !== 3'd0) begin errors++; $display("FAIL reset_starve got %0d want 0", starve_cnt); end
    checks++; if (d_ar_ready !== 1'b0 || m_r_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got d_ar %0b m_r %0b want 0 0", d_ar_ready, m_r_ready); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_demand;
    @(negedge clk);
    en = 1'b1; m_ar_ready = 1'b0; d_r_ready = 1'b1;
    d_ar_valid = 1'b1; d_ar_addr = 16'h0EEF; d_ar_len = 8'd0; d_ar_id = 8'd5;
    #1;
    checks++; if (d_ar_ready !== 1'b1) begin errors++; $display("FAIL single_d_ar_ready got %0b want 1", d_ar_ready); end
    @(negedge clk);
    d_ar_valid = 1'b0;
    #1;
    checks++; if (m_ar_valid !== 1'b1) begin errors++; $display("FAIL single_m_ar_valid got %0b want 1", m_ar_valid); end
    checks++; if (m_ar_addr !== 16'h0EEF || m_ar_len !== 8'd0 || m_ar_id !== 8'd5) begin errors++; $display("FAIL single_payload got %h/%0d/%0d want 0eef/0/5", m_ar_addr, m_ar_len, m_ar_id); end
    checks++; if (outstanding !== 4'd1) begin errors++; $display("FAIL single_outstanding1 got %0d want 1", outstanding); end
    m_ar_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (m_ar_valid !== 1'b0) begin errors++; $display("FAIL single_ar_done got %0b want 0", m_ar_valid); end
    m_r_valid = 1'b1; m_r_last = 1'b1; m_r_data = 8'hA5; m_r_id = 8'd5;
    #1;
    checks++; if (d_r_valid !== 1'b1 || p_r_valid !== 1'b0 || m_r_ready !== 1'b1) begin errors++; $display("FAIL single_r_route got d %0b p %0b rdy %0b want 1 0 1", d_r_valid, p_r_valid, m_r_ready); end
    checks++; if (d_r_data !== 8'hA5 || d_r_last !== 1'b1 || d_r_id !== 8'd5) begin errors++; $display("FAIL single_r_payload got %h/%0b/%0d want a5/1/5", d_r_data, d_r_last, d_r_id); end
    @(negedge clk);
    m_r_valid = 1'b0;
    #1;
    checks++; if (outstanding !== 4'd0) begin errors++; $display("FAIL single_outstanding0 got %0d want 0", outstanding); end
  endtask

  task automatic test_starvation;
    bit exp_p;
    logic [2:0] exp_s;
    @(negedge clk);
    crs_starve_limit = 3'd3; m_ar_ready = 1'b1;
    d_ar_valid = 1'b1; d_ar_len = 8'd0; p_ar_valid = 1'b1; p_ar_len = 8'd0;
    m_r_valid = 1'b1; m_r_last = 1'b1; d_r_ready = 1'b1; p_r_ready = 1'b1;
    exp_s = 3'd0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (i > 0) begin
        checks++; if (starve_cnt !== exp_s) begin errors++; $display("FAIL starve_cnt_%0d got %0d want %0d", i, starve_cnt, exp_s); end
      end
      exp_p = (i % 4 == 3);
      checks++; if (d_ar_ready !== !exp_p || p_ar_ready !== exp_p) begin errors++; $display("FAIL starve_grant_%0d got d %0b p %0b want p=%0b", i, d_ar_ready, p_ar_ready, exp_p); end
      exp_s = exp_p ? 3'd0 : exp_s + 3'd1;
      @(negedge clk);
    end
    #1;
    checks++; if (starve_cnt !== 3'd0) begin errors++; $display("FAIL starve_cnt_end got %0d want 0", starve_cnt); end
    d_ar_valid = 1'b0; p_ar_valid = 1'b0;
    repeat (2) @(negedge clk);
    m_r_valid = 1'b0;
  endtask

  task automatic test_strict_priority;
    @(negedge clk);
    crs_starve_limit = 3'd0; m_ar_ready = 1'b1;
    d_ar_valid = 1'b1; p_ar_valid = 1'b1;
    m_r_valid = 1'b1; m_r_last = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++; if (d_ar_ready !== 1'b1 || p_ar_ready !== 1'b0) begin errors++; $display("FAIL strict_grant_%0d got d %0b p %0b want 1 0", i, d_ar_ready, p_ar_ready); end
      @(negedge clk);
    end
    #1;
    checks++; if (starve_cnt !== 3'd7) begin errors++; $display("FAIL strict_saturate got %0d want 7", starve_cnt); end
    d_ar_valid = 1'b0; p_ar_valid = 1'b0;
    repeat (2) @(negedge clk);
    m_r_valid = 1'b0;
    #1;
    checks++; if (outstanding !== 4'd0) begin errors++; $display("FAIL strict_drain got %0d want 0", outstanding); end
  endtask

  task automatic test_outstanding_full;
    @(negedge clk);
    m_ar_ready = 1'b1; m_r_valid = 1'b0; d_r_ready = 1'b1; d_ar_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++; if (d_ar_ready !== 1'b1) begin errors++; $display("FAIL full_grant_%0d got %0b want 1", i, d_ar_ready); end
      @(negedge clk);
    end
    #1;
    checks++; if (d_ar_ready !== 1'b0 || outstanding !== 4'd8) begin errors++; $display("FAIL full_block got rdy %0b cnt %0d want 0 8", d_ar_ready, outstanding); end
    m_r_valid = 1'b1; m_r_last = 1'b1;
    #1;
    checks++; if (d_ar_ready !== 1'b0) begin errors++; $display("FAIL full_pop_same_cycle got %0b want 0", d_ar_ready); end
    @(negedge clk);
    m_r_valid = 1'b0;
    #1;
    checks++; if (outstanding !== 4'd7 || d_ar_ready !== 1'b1) begin errors++; $display("FAIL full_after_pop got cnt %0d rdy %0b want 7 1", outstanding, d_ar_ready); end
    @(negedge clk);
    #1;
    checks++; if (outstanding !== 4'd8 || d_ar_ready !== 1'b0) begin errors++; $display("FAIL full_ninth got cnt %0d rdy %0b want 8 0", outstanding, d_ar_ready); end
    d_ar_valid = 1'b0; m_r_valid = 1'b1;
    for (int k = 0; k < 20 && outstanding != 4'd0; k++) @(negedge clk);
    m_r_valid = 1'b0;
    #1;
    checks++; if (outstanding !== 4'd0) begin errors++; $display("FAIL full_drain got %0d want 0", outstanding); end
  endtask

  task automatic test_ordering;
    @(negedge clk);
    m_ar_ready = 1'b1; m_r_valid = 1'b0; d_r_ready = 1'b1; p_r_ready = 1'b0;
    d_ar_valid = 1'b1; d_ar_len = 8'd3;
    @(negedge clk);
    d_ar_valid = 1'b0; p_ar_valid = 1'b1; p_ar_len = 8'd1;
    @(negedge clk);
    p_ar_valid = 1'b0; d_ar_valid = 1'b1; d_ar_len = 8'd0;
    #1;
    checks++; if (m_ar_len !== 8'd1) begin errors++; $display("FAIL order_p_len got %0d want 1", m_ar_len); end
    @(negedge clk);
    d_ar_valid = 1'b0;
    #1;
    checks++; if (outstanding !== 4'd3) begin errors++; $display("FAIL order_issued got %0d want 3", outstanding); end
    for (int b = 0; b < 4; b++) begin
      m_r_valid = 1'b1; m_r_last = (b == 3); m_r_data = 8'(b);
      #1;
      checks++; if (d_r_valid !== 1'b1 || p_r_valid !== 1'b0 || m_r_ready !== 1'b1) begin errors++; $display("FAIL order_d0_beat%0d got d %0b p %0b rdy %0b want 1 0 1", b, d_r_valid, p_r_valid, m_r_ready); end
      @(negedge clk);
    end
    m_r_last = 1'b0;
    for (int s = 0; s < 2; s++) begin
      #1;
      checks++; if (p_r_valid !== 1'b1 || d_r_valid !== 1'b0 || m_r_ready !== 1'b0) begin errors++; $display("FAIL order_stall%0d got p %0b d %0b rdy %0b want 1 0 0", s, p_r_valid, d_r_valid, m_r_ready); end
      @(negedge clk);
    end
    #1;
    checks++; if (outstanding !== 4'd2) begin errors++; $display("FAIL order_stall_cnt got %0d want 2", outstanding); end
    p_r_ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      m_r_last = (b == 1);
      #1;
      checks++; if (p_r_valid !== 1'b1 || d_r_valid !== 1'b0 || m_r_ready !== 1'b1 || p_r_last !== (b == 1)) begin errors++; $display("FAIL order_p_beat%0d got p %0b d %0b rdy %0b last %0b", b, p_r_valid, d_r_valid, m_r_ready, p_r_last); end
      @(negedge clk);
    end
    m_r_last = 1'b1;
    #1;
    checks++; if (d_r_valid !== 1'b1 || p_r_valid !== 1'b0) begin errors++; $display("FAIL order_d2_beat got d %0b p %0b want 1 0", d_r_valid, p_r_valid); end
    @(negedge clk);
    m_r_valid = 1'b0;
    #1;
    checks++; if (outstanding !== 4'd0) begin errors++; $display("FAIL order_done got %0d want 0", outstanding); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    m_ar_ready = 1'b1; m_r_valid = 1'b0; d_ar_valid = 1'b1; d_ar_len = 8'd0;
    @(negedge clk);
    @(negedge clk);
    d_ar_valid = 1'b0; m_ar_ready = 1'b0;
    #1;
    checks++; if (outstanding !== 4'd2 || m_ar_valid !== 1'b1) begin errors++; $display("FAIL mid_setup got cnt %0d v %0b want 2 1", outstanding, m_ar_valid); end
    #1;
    rst = 1'b1; d_ar_valid = 1'b1; p_ar_valid = 1'b1; m_r_valid = 1'b1; m_r_last = 1'b1;
    #1;
    checks++; if (m_ar_valid !== 1'b0 || m_ar_addr !== 16'h0 || m_ar_len !== 8'd0 || m_ar_id !== 8'd0) begin errors++; $display("FAIL mid_ar got v %0b %h/%0d/%0d want 0 0/0/0", m_ar_valid, m_ar_addr, m_ar_len, m_ar_id); end
    checks++; if (outstanding !== 4'd0 || starve_cnt !== 3'd0) begin errors++; $display("FAIL mid_counts got %0d %0d want 0 0", outstanding, starve_cnt); end
    checks++; if (d_ar_ready !== 1'b0 || p_ar_ready !== 1'b0 || d_r_valid !== 1'b0 || p_r_valid !== 1'b0 || m_r_ready !== 1'b0) begin errors++; $display("FAIL mid_handshakes got %0b%0b%0b%0b%0b want 00000", d_ar_ready, p_ar_ready, d_r_valid, p_r_valid, m_r_ready); end
    @(negedge clk);
    rst = 1'b0; d_ar_valid = 1'b0; p_ar_valid = 1'b0; m_r_valid = 1'b0;
    test_single_demand();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; crs_starve_limit = 3'd0;
    d_ar_valid = 1'b0; d_ar_addr = '0; d_ar_len = '0; d_ar_id = '0;
    p_ar_valid = 1'b0; p_ar_addr = 16'h1234; p_ar_len = '0; p_ar_id = 8'd9;
    m_ar_ready = 1'b0; m_r_valid = 1'b0; m_r_last = 1'b0; m_r_data = '0; m_r_id = '0;
    d_r_ready = 1'b0; p_r_ready = 1'b0;
    test_reset();
    test_single_demand();
    test_starvation();
    test_strict_priority();
    test_outstanding_full();
    test_ordering();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
